// File: rtl/fix_mul_arbiter_if.sv
// Requester-side bus of the shared fixed-point multiplier arbiter: operand
// handshake from the PE lanes and the one-hot result return path.
interface fix_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
) ();
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       res_valid;
    logic [WIDTH-1:0]         res_data;
    logic                     res_ovf;
    logic                     busy;

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_data, res_ovf, busy
    );

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_data, res_ovf, busy
    );
endinterface

// File: rtl/fix_mul_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier between NUM_REQ lanes,
// with a tag pipeline routing rescaled products back. FIX_MUL_SAT_EN enables saturation.
module fix_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int POINT_WIDTH = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fix_mul_arbiter_if.slave     req_if,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p
);
    localparam int IDW    = $clog2(NUM_REQ);
    localparam int STAGES = MUL_LATENCY + 1;
    localparam int TOPW   = WIDTH - POINT_WIDTH + 1;

    // Product overflows the WIDTH-bit result when its upper bits are not pure sign extension
    function automatic logic is_ovf(input logic [2*WIDTH-1:0] p);
        logic [TOPW-1:0] top;
        top = p[2*WIDTH-1 : POINT_WIDTH+WIDTH-1];
        return !((&top) || !(|top));
    endfunction

    function automatic logic [WIDTH-1:0] rescale(input logic [2*WIDTH-1:0] p);
`ifdef FIX_MUL_SAT_EN
        if (is_ovf(p)) begin
            return p[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            return p[POINT_WIDTH +: WIDTH];
        end
`else
        return p[POINT_WIDTH +: WIDTH];
`endif
    endfunction

    logic [IDW-1:0]               ptr_r;
    logic [IDW-1:0]               grant_id_s;
    logic [NUM_REQ-1:0]           grant_s;
    logic                         issue_s;
    logic [WIDTH-1:0]             win_a_s;
    logic [WIDTH-1:0]             win_b_s;
    logic [WIDTH-1:0]             mul_a_r;
    logic [WIDTH-1:0]             mul_b_r;
    logic [STAGES-1:0]            tag_vld_r;
    logic [STAGES-1:0][IDW-1:0]   tag_id_r;
    logic [NUM_REQ-1:0]           res_onehot_s;
    logic [WIDTH-1:0]             res_data_s;
    logic                         res_ovf_s;
    logic [NUM_REQ-1:0]           res_valid_r;
    logic [WIDTH-1:0]             res_data_r;
    logic                         res_ovf_r;
    logic                         unused_low_bits_s;

    // Round-robin search starting one past the last winner; first hit wins
    always_comb begin
        int  idx;
        logic hit;
        grant_s    = '0;
        grant_id_s = '0;
        issue_s    = 1'b0;
        idx        = 0;
        hit        = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx          = (int'(ptr_r) + off) % NUM_REQ;
            hit          = !issue_s && req_if.req_valid[idx];
            grant_s[idx] = grant_s[idx] | hit;
            grant_id_s   = hit ? IDW'(idx) : grant_id_s;
            issue_s      = issue_s | hit;
        end
    end

    assign win_a_s = req_if.req_a[int'(grant_id_s)*WIDTH +: WIDTH];
    assign win_b_s = req_if.req_b[int'(grant_id_s)*WIDTH +: WIDTH];

    // Operand registers and RR pointer; operands hold on idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_r <= '0;
            mul_b_r <= '0;
            ptr_r   <= IDW'(NUM_REQ - 1);
        end else if (issue_s) begin
            mul_a_r <= win_a_s;
            mul_b_r <= win_b_s;
            ptr_r   <= grant_id_s;
        end
    end

    // Tag pipeline: stage 0 aligns with mul_a/mul_b, last stage aligns with mul_p
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r <= '0;
            tag_id_r  <= '0;
        end else begin
            tag_vld_r <= {tag_vld_r[STAGES-2:0], issue_s};
            tag_id_r  <= {tag_id_r[STAGES-2:0], grant_id_s};
        end
    end

    // Decode the returning tag and rescale the product
    always_comb begin
        res_onehot_s = '0;
        res_onehot_s[tag_id_r[STAGES-1]] = tag_vld_r[STAGES-1];
        res_data_s   = rescale(mul_p);
        res_ovf_s    = is_ovf(mul_p);
    end

    // Registered result; data and flag hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= '0;
            res_data_r  <= '0;
            res_ovf_r   <= 1'b0;
        end else begin
            res_valid_r <= res_onehot_s;
            if (tag_vld_r[STAGES-1]) begin
                res_data_r <= res_data_s;
                res_ovf_r  <= res_ovf_s;
            end
        end
    end

    assign unused_low_bits_s = &{1'b0, mul_p[POINT_WIDTH-1:0]};

    assign mul_a            = mul_a_r;
    assign mul_b            = mul_b_r;
    assign req_if.req_ready = grant_s;
    assign req_if.res_valid = res_valid_r;
    assign req_if.res_data  = res_data_r;
    assign req_if.res_ovf   = res_ovf_r;
    assign req_if.busy      = (|req_if.req_valid) | (|tag_vld_r);
endmodule
